perceptron_seq: RTL and testbench

//   Parametrised N-input perceptron with on-line training. Accepts one sample per

---
 rtl/perceptron_pkg.sv | 17 +
 rtl/perceptron_if.sv | 31 +++
 rtl/perceptron_sat_add.sv | 31 +++
 rtl/perceptron_seq.sv | 156 +++++++++++++++
 tb/tb_perceptron_seq.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/perceptron_pkg.sv
// Shared types and width helpers for the sequential perceptron.
package perceptron_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        CMP,
        UPD,
        RESP
    } state_t;

    // Headroom for N_IN products of an unsigned input times a signed weight.
    function automatic int acc_width(input int n_in, input int in_w, input int w_w);
        return in_w + w_w + $clog2(n_in) + 1;
    endfunction

endpackage

// File: rtl/perceptron_if.sv
// Sample-in / result-out handshake bundle; master is the source/consumer side.
interface perceptron_if
    import perceptron_pkg::*;
#(
    parameter int N_IN = 3,
    parameter int IN_W = 8,
    parameter int W_W  = 16
);
    localparam int ACC_W = acc_width(N_IN, IN_W, W_W);

    logic                    in_valid;
    logic                    in_ready;
    logic [N_IN*IN_W-1:0]    in_data;
    logic                    in_train;
    logic                    in_desired;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_y;
    logic                    out_err;
    logic signed [ACC_W-1:0] out_sum;

    modport master (
        output in_valid, in_data, in_train, in_desired, out_ready,
        input  in_ready, out_valid, out_y, out_err, out_sum
    );

    modport slave (
        input  in_valid, in_data, in_train, in_desired, out_ready,
        output in_ready, out_valid, out_y, out_err, out_sum
    );
endinterface

// File: rtl/perceptron_sat_add.sv
// Signed weight plus/minus an unsigned step, clamped to the weight's signed range.
module perceptron_sat_add #(
    parameter int IN_W = 8,
    parameter int W_W  = 16
) (
    input  logic signed [W_W-1:0] w,
    input  logic [IN_W-1:0]       d,
    input  logic                  sub,
    output logic signed [W_W-1:0] result
);
    localparam int SUM_W = ((W_W > IN_W + 1) ? W_W : IN_W + 1) + 1;
    localparam logic signed [SUM_W-1:0] W_MAX = SUM_W'({1'b0, {(W_W-1){1'b1}}});
    localparam logic signed [SUM_W-1:0] W_MIN = -W_MAX - SUM_W'(1);

    logic signed [SUM_W-1:0] w_ext;
    logic signed [SUM_W-1:0] d_ext;
    logic signed [SUM_W-1:0] sum;

    assign w_ext = SUM_W'(w);
    assign d_ext = SUM_W'({1'b0, d});
    assign sum   = sub ? (w_ext - d_ext) : (w_ext + d_ext);

    always_comb begin
        result = sum[W_W-1:0];
        if (sum > W_MAX) begin
            result = W_MAX[W_W-1:0];
        end else if (sum < W_MIN) begin
            result = W_MIN[W_W-1:0];
        end
    end
endmodule

// File: rtl/perceptron_seq.sv
// N-input perceptron: one shared MAC over N_IN cycles, threshold compare, optional saturating update.
//   state | meaning
//   IDLE  | waiting for a sample, in_ready high
//   MAC   | accumulate x[idx]*w[idx], one input per cycle
//   CMP   | threshold compare, latch result, count training errors
//   UPD   | apply learning rule to w[idx], one weight per cycle
//   RESP  | out_valid held until consumer takes it
module perceptron_seq
    import perceptron_pkg::*;
#(
    parameter int     N_IN        = 3,
    parameter int     IN_W        = 8,
    parameter int     W_W         = 16,
    parameter int     WEIGHT_INIT = 10,
    parameter longint THRESH      = 200,
    parameter int     LR_SHIFT    = 3,
    localparam int    SEL_W       = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    perceptron_if.slave           bus,
    output logic [15:0]           err_count,
    input  logic [SEL_W-1:0]      w_sel,
    output logic signed [W_W-1:0] w_rdata
);
    localparam int ACC_W = acc_width(N_IN, IN_W, W_W);
    // Widen the compare so thresholds beyond the accumulator range still behave.
    localparam int CMP_W = (ACC_W > 64) ? ACC_W : 64;
    localparam logic signed [CMP_W-1:0] THRESH_EXT = CMP_W'(THRESH);
    localparam logic [SEL_W-1:0]        IDX_LAST   = SEL_W'(N_IN - 1);
    localparam logic signed [W_W-1:0]   W_RESET    = W_W'(WEIGHT_INIT);

    state_t                  state;
    logic [SEL_W-1:0]        idx;
    logic [IN_W-1:0]         x_reg [N_IN];
    logic signed [W_W-1:0]   w     [N_IN];
    logic                    train_reg;
    logic                    desired_reg;
    logic signed [ACC_W-1:0] acc;

    logic [IN_W-1:0]         x_cur;
    logic signed [W_W-1:0]   w_cur;
    logic signed [W_W-1:0]   w_next;
    logic [IN_W-1:0]         d_step;
    logic signed [ACC_W-1:0] prod;
    logic                    y_now;

    always_comb begin
        x_cur = '0;
        w_cur = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (idx == SEL_W'(i)) begin
                x_cur = x_reg[i];
                w_cur = w[i];
            end
        end
    end

    assign prod   = ACC_W'(signed'({1'b0, x_cur})) * ACC_W'(w_cur);
    assign y_now  = (CMP_W'(acc) >= THRESH_EXT);
    assign d_step = x_cur >> LR_SHIFT;

    perceptron_sat_add #(
        .IN_W (IN_W),
        .W_W  (W_W)
    ) u_sat_add (
        .w      (w_cur),
        .d      (d_step),
        .sub    (!desired_reg),
        .result (w_next)
    );

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (w_sel == SEL_W'(i)) w_rdata = w[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            acc           <= '0;
            train_reg     <= 1'b0;
            desired_reg   <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_y     <= 1'b0;
            bus.out_err   <= 1'b0;
            bus.out_sum   <= '0;
            err_count     <= '0;
            for (int i = 0; i < N_IN; i++) begin
                w[i]     <= W_RESET;
                x_reg[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        for (int i = 0; i < N_IN; i++) begin
                            x_reg[i] <= bus.in_data[i*IN_W +: IN_W];
                        end
                        train_reg    <= bus.in_train;
                        desired_reg  <= bus.in_desired;
                        acc          <= '0;
                        idx          <= '0;
                        bus.in_ready <= 1'b0;
                        state        <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + prod;
                    if (idx == IDX_LAST) begin
                        idx   <= '0;
                        state <= CMP;
                    end else begin
                        idx <= idx + SEL_W'(1);
                    end
                end
                CMP: begin
                    bus.out_y   <= y_now;
                    bus.out_err <= (y_now != desired_reg);
                    bus.out_sum <= acc;
                    if (train_reg && (y_now != desired_reg)) begin
                        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                        state <= UPD;
                    end else begin
                        bus.out_valid <= 1'b1;
                        state         <= RESP;
                    end
                end
                UPD: begin
                    for (int i = 0; i < N_IN; i++) begin
                        if (idx == SEL_W'(i)) w[i] <= w_next;
                    end
                    if (idx == IDX_LAST) begin
                        idx           <= '0;
                        bus.out_valid <= 1'b1;
                        state         <= RESP;
                    end else begin
                        idx <= idx + SEL_W'(1);
                    end
                end
                RESP: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_perceptron_seq.sv
// Directed bench for perceptron_seq: default instance plus a narrow-weight instance for clamping.
module tb_perceptron_seq;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    perceptron_if #(.N_IN(3), .IN_W(8), .W_W(16)) bus ();
    perceptron_if #(.N_IN(3), .IN_W(8), .W_W(8))  bus8 ();

    logic [15:0]        err_count;
    logic [1:0]         w_sel;
    logic signed [15:0] w_rdata;
    logic [15:0]        err_count8;
    logic [1:0]         w_sel8;
    logic signed [7:0]  w_rdata8;

    int checks   = 0;
    int failures = 0;

    perceptron_seq #(
        .N_IN(3), .IN_W(8), .W_W(16), .WEIGHT_INIT(10), .THRESH(200), .LR_SHIFT(3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .err_count (err_count),
        .w_sel     (w_sel),
        .w_rdata   (w_rdata)
    );

    perceptron_seq #(
        .N_IN(3), .IN_W(8), .W_W(8), .WEIGHT_INIT(120), .THRESH(64'sd1048576), .LR_SHIFT(3)
    ) dut8 (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus8.slave),
        .err_count (err_count8),
        .w_sel     (w_sel8),
        .w_rdata   (w_rdata8)
    );

    // Present one sample; lat counts edges from the accept edge (inclusive) to out_valid, -1 on timeout.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic train, input logic desired, output int lat);
        @(negedge clk);
        bus.in_data    = {c, b, a};
        bus.in_train   = train;
        bus.in_desired = desired;
        bus.in_valid   = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.out_valid) lat = -1;
    endtask

    task automatic complete();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int exp_w;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        checks++; if (bus.out_y !== 1'b0 || bus.out_err !== 1'b0) begin failures++; $display("FAIL reset_y_err got=%b%b want=00", bus.out_y, bus.out_err); end
        checks++; if (int'($signed(bus.out_sum)) !== 0) begin failures++; $display("FAIL reset_out_sum got=%0d want=0", $signed(bus.out_sum)); end
        checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL reset_err_count got=%0d want=0", err_count); end
        exp_w = 10;
        for (int i = 0; i < 3; i++) begin
            w_sel = 2'(i); #1;
            checks++; if (int'(w_rdata) !== exp_w) begin failures++; $display("FAIL reset_weight%0d got=%0d want=%0d", i, w_rdata, exp_w); end
        end
        w_sel = 2'd3; #1;
        checks++; if (w_rdata !== 16'sd0) begin failures++; $display("FAIL readback_out_of_range got=%0d want=0", w_rdata); end
        w_sel8 = 2'd0; #1;
        checks++; if (int'(w_rdata8) !== 120) begin failures++; $display("FAIL reset8_weight got=%0d want=120", w_rdata8); end
    endtask

    task automatic test_infer();
        int lat;
        send(8'd5, 8'd5, 8'd5, 1'b0, 1'b0, lat);
        checks++; if (lat !== 5) begin failures++; $display("FAIL infer_latency got=%0d want=5", lat); end
        checks++; if (int'($signed(bus.out_sum)) !== 150) begin failures++; $display("FAIL infer_sum got=%0d want=150", $signed(bus.out_sum)); end
        checks++; if (bus.out_y !== 1'b0 || bus.out_err !== 1'b0) begin failures++; $display("FAIL infer_y_err got=%b%b want=00", bus.out_y, bus.out_err); end
        complete();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL infer_release got=v%b r%b want=v0 r1", bus.out_valid, bus.in_ready); end
        checks++; if (int'($signed(bus.out_sum)) !== 150) begin failures++; $display("FAIL infer_sum_held got=%0d want=150", $signed(bus.out_sum)); end
        for (int i = 0; i < 3; i++) begin
            w_sel = 2'(i); #1;
            checks++; if (int'(w_rdata) !== 10) begin failures++; $display("FAIL infer_weight%0d got=%0d want=10", i, w_rdata); end
        end
    endtask

    task automatic test_no_update();
        int lat;
        send(8'd10, 8'd5, 8'd5, 1'b1, 1'b1, lat);
        checks++; if (lat !== 5) begin failures++; $display("FAIL noupd_latency got=%0d want=5", lat); end
        checks++; if (int'($signed(bus.out_sum)) !== 200) begin failures++; $display("FAIL noupd_sum got=%0d want=200", $signed(bus.out_sum)); end
        checks++; if (bus.out_y !== 1'b1 || bus.out_err !== 1'b0) begin failures++; $display("FAIL noupd_y_err got=%b%b want=10", bus.out_y, bus.out_err); end
        checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL noupd_err_count got=%0d want=0", err_count); end
        complete();
    endtask

    task automatic test_update();
        int lat;
        int exp_w [3];
        exp_w = '{0, 5, 8};
        send(8'd80, 8'd40, 8'd16, 1'b1, 1'b0, lat);
        checks++; if (lat !== 8) begin failures++; $display("FAIL upd_latency got=%0d want=8", lat); end
        checks++; if (int'($signed(bus.out_sum)) !== 1360) begin failures++; $display("FAIL upd_sum got=%0d want=1360", $signed(bus.out_sum)); end
        checks++; if (bus.out_y !== 1'b1 || bus.out_err !== 1'b1) begin failures++; $display("FAIL upd_y_err got=%b%b want=11", bus.out_y, bus.out_err); end
        checks++; if (err_count !== 16'd1) begin failures++; $display("FAIL upd_err_count got=%0d want=1", err_count); end
        complete();
        for (int i = 0; i < 3; i++) begin
            w_sel = 2'(i); #1;
            checks++; if (int'(w_rdata) !== exp_w[i]) begin failures++; $display("FAIL upd_weight%0d got=%0d want=%0d", i, w_rdata, exp_w[i]); end
        end
    endtask

    task automatic test_hold();
        int lat;
        int bad;
        send(8'd10, 8'd10, 8'd10, 1'b0, 1'b1, lat);
        checks++; if (lat !== 5) begin failures++; $display("FAIL hold_latency got=%0d want=5", lat); end
        checks++; if (int'($signed(bus.out_sum)) !== 130) begin failures++; $display("FAIL hold_sum got=%0d want=130", $signed(bus.out_sum)); end
        checks++; if (bus.out_y !== 1'b0 || bus.out_err !== 1'b1) begin failures++; $display("FAIL hold_y_err got=%b%b want=01", bus.out_y, bus.out_err); end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.in_data  = {8'd200, 8'd200, 8'd200};
            bus.in_train = 1'b1;
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_y !== 1'b0 ||
                int'($signed(bus.out_sum)) !== 130) begin
                failures++;
                $display("FAIL hold_cycle%0d got=v%b r%b y%b sum%0d want=v1 r0 y0 sum130",
                         c, bus.out_valid, bus.in_ready, bus.out_y, $signed(bus.out_sum));
            end
        end
        bus.in_valid = 1'b0;
        bus.in_train = 1'b0;
        complete();
        checks++; if (err_count !== 16'd1) begin failures++; $display("FAIL hold_err_count got=%0d want=1", err_count); end
        @(posedge clk); #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL hold_idle got=r%b v%b want=r1 v0", bus.in_ready, bus.out_valid); end
        w_sel = 2'd2; #1;
        checks++; if (int'(w_rdata) !== 8) begin failures++; $display("FAIL hold_weight2 got=%0d want=8", w_rdata); end
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge clk);
        bus.in_data    = {8'd16, 8'd40, 8'd80};
        bus.in_train   = 1'b1;
        bus.in_desired = 1'b0;
        bus.in_valid   = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL midreset_state got=r%b v%b want=r1 v0", bus.in_ready, bus.out_valid); end
        checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL midreset_err_count got=%0d want=0", err_count); end
        for (int i = 0; i < 3; i++) begin
            w_sel = 2'(i); #1;
            checks++; if (int'(w_rdata) !== 10) begin failures++; $display("FAIL midreset_weight%0d got=%0d want=10", i, w_rdata); end
        end
        send(8'd5, 8'd5, 8'd5, 1'b0, 1'b0, lat);
        checks++; if (lat !== 5 || int'($signed(bus.out_sum)) !== 150) begin failures++; $display("FAIL midreset_rerun got=lat%0d sum%0d want=lat5 sum150", lat, $signed(bus.out_sum)); end
        complete();
    endtask

    task automatic test_saturate();
        int lat;
        @(negedge clk);
        bus8.in_data    = {8'd255, 8'd255, 8'd255};
        bus8.in_train   = 1'b1;
        bus8.in_desired = 1'b1;
        bus8.in_valid   = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        lat = 1;
        while (!bus8.out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus8.out_valid) lat = -1;
        checks++; if (lat !== 8) begin failures++; $display("FAIL sat_latency got=%0d want=8", lat); end
        checks++; if (int'($signed(bus8.out_sum)) !== 91800) begin failures++; $display("FAIL sat_sum got=%0d want=91800", $signed(bus8.out_sum)); end
        checks++; if (bus8.out_y !== 1'b0 || bus8.out_err !== 1'b1) begin failures++; $display("FAIL sat_y_err got=%b%b want=01", bus8.out_y, bus8.out_err); end
        checks++; if (err_count8 !== 16'd1) begin failures++; $display("FAIL sat_err_count got=%0d want=1", err_count8); end
        for (int i = 0; i < 3; i++) begin
            w_sel8 = 2'(i); #1;
            checks++; if (int'(w_rdata8) !== 127) begin failures++; $display("FAIL sat_weight%0d got=%0d want=127", i, w_rdata8); end
        end
        @(negedge clk);
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
        checks++; if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1) begin failures++; $display("FAIL sat_release got=v%b r%b want=v0 r1", bus8.out_valid, bus8.in_ready); end
    endtask

    initial begin
        reset           = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.in_train    = 1'b0;
        bus.in_desired  = 1'b0;
        bus.out_ready   = 1'b0;
        bus8.in_valid   = 1'b0;
        bus8.in_data    = '0;
        bus8.in_train   = 1'b0;
        bus8.in_desired = 1'b0;
        bus8.out_ready  = 1'b0;
        w_sel           = 2'd0;
        w_sel8          = 2'd0;

        test_reset();
        test_infer();
        test_no_update();
        test_update();
        test_hold();
        test_reset_mid();
        test_saturate();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
